// File: rtl/btn_led_ctrl.sv
// rtl/btn_led_ctrl.sv - front-panel button debounce, press detect and LED mode controller
//
// Purpose: per-channel 2-flop synchroniser, counting debouncer and rising-edge
// press detector, plus a registered LED driver selectable between direct,
// toggle, blinking-toggle and off.
// Optional: define BTN_LED_DIM_EN to dim every LED to 25% duty.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   btn[N]     raw asynchronous buttons, active high
//   mode[2]    LED mode: 0 direct, 1 toggle, 2 blink, 3 off
//   btn_db[N]  debounced button level
//   btn_press[N] one-cycle pulse per debounced rising edge
//   led[N]     LED drive, active high
module btn_led_ctrl #(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 500000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn,
  input  logic [1:0]   mode,
  output logic [N-1:0] btn_db,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] led
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [N-1:0]  s1_q, s2_q;
  logic [N-1:0]  db_q, db_d;
  logic [N-1:0]  press_q, press_d;
  logic [N-1:0]  tog_q, tog_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [N-1:0]  led_q, led_d;

  always_comb begin
    db_d    = db_q;
    press_d = '0;
    // Toggle follows the registered press pulse, so it flips one edge later.
    tog_d   = tog_q ^ press_q;
    for (int i = 0; i < N; i++) begin
      // Any cycle where the synced level agrees with the accepted level
      // restarts the stability count, which is what rejects bounce.
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          db_d[i]    = s2_q[i];
          press_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      blink_ph_d  = blink_ph_q;
    end

    case (mode)
      2'd0:    led_d = db_q;
      2'd1:    led_d = tog_q;
      2'd2:    led_d = tog_q & {N{blink_ph_q}};
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      db_q        <= '0;
      press_q     <= '0;
      tog_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      led_q       <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q        <= btn;
      s2_q        <= s1_q;
      db_q        <= db_d;
      press_q     <= press_d;
      tog_q       <= tog_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      led_q       <= led_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_db    = db_q;
  assign btn_press = press_q;

`ifdef BTN_LED_DIM_EN
  // LEDs are lit only on one cycle out of every four.
  logic [1:0] dim_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dim_cnt_q <= 2'b00;
    end else begin
      dim_cnt_q <= dim_cnt_q + 2'd1;
    end
  end

  assign led = led_q & {N{dim_cnt_q == 2'b00}};
`else
  assign led = led_q;
`endif

endmodule

// File: tb/tb_btn_led_ctrl.sv
// tb/tb_btn_led_ctrl.sv - scoreboard bench for btn_led_ctrl
module tb_btn_led_ctrl;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int BLK = 8;

  localparam int SEL_DB  = 0;
  localparam int SEL_PR  = 1;
  localparam int SEL_LED = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [1:0]   mode;
  logic [N-1:0] btn_db;
  logic [N-1:0] btn_press;
  logic [N-1:0] led;

  btn_led_ctrl #(
    .N(N),
    .DEB_CYCLES(DEB),
    .BLINK_DIV(BLK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .mode(mode),
    .btn_db(btn_db),
    .btn_press(btn_press),
    .led(led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         sel;
    logic [3:0] mask;
    logic [3:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_at(input int at, input int sel, input logic [3:0] mask,
                           input logic [3:0] val, input string tag);
    exp_t e;
    e.at   = at;
    e.sel  = sel;
    e.mask = mask;
    e.val  = val & mask;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic expect_win(input int from, input int to, input int sel,
                            input logic [3:0] mask, input logic [3:0] val, input string tag);
    for (int k = from; k <= to; k++) expect_at(k, sel, mask, val, tag);
  endtask

  function automatic logic [3:0] pick(input int sel);
    case (sel)
      SEL_DB:  return btn_db;
      SEL_PR:  return btn_press;
      default: return led;
    endcase
  endfunction

  // Outputs settle after the posedge; compare every entry due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check(sb[i].tag, {28'd0, pick(sb[i].sel) & sb[i].mask}, {28'd0, sb[i].val});
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int c, cr, cm, e;
  logic [3:0] ev;

  initial begin
    rst  = 1'b1;
    btn  = 4'hF;
    mode = 2'd0;
    step(1);

    // 1: reset with all buttons held, then debounce of the held level
    c = cyc;
    expect_win(c + 1, c + 3, SEL_DB,  4'hF, 4'h0, "rst_db");
    expect_win(c + 1, c + 3, SEL_PR,  4'hF, 4'h0, "rst_press");
    expect_win(c + 1, c + 3, SEL_LED, 4'hF, 4'h0, "rst_led");
    step(3);
    rst = 1'b0;
    c = cyc;
    expect_win(c + 1, c + 5, SEL_DB, 4'hF, 4'h0, "t1_db_wait");
    expect_at(c + 6, SEL_DB, 4'hF, 4'hF, "t1_db_rise");
    expect_win(c + 1, c + 5, SEL_PR, 4'hF, 4'h0, "t1_press_quiet");
    expect_at(c + 6, SEL_PR, 4'hF, 4'hF, "t1_press");
    expect_at(c + 7, SEL_PR, 4'hF, 4'h0, "t1_press_end");
    expect_at(c + 7, SEL_LED, 4'hF, 4'hF, "t1_led_direct");
    step(10);
    btn = 4'h0;
    c = cyc;
    expect_at(c + 5, SEL_DB, 4'hF, 4'hF, "t1_db_hold");
    expect_at(c + 6, SEL_DB, 4'hF, 4'h0, "t1_db_fall");
    expect_win(c + 1, c + 10, SEL_PR, 4'hF, 4'h0, "t1_no_release_press");
    expect_at(c + 7, SEL_LED, 4'hF, 4'h0, "t1_led_off");
    step(12);

    // 2: bounce rejection on channel 0
    c = cyc;
    expect_win(c + 1, c + 25, SEL_DB, 4'h1, 4'h0, "t2_db_bounce");
    expect_at(c + 26, SEL_DB, 4'h1, 4'h1, "t2_db_rise");
    expect_win(c + 1, c + 25, SEL_PR, 4'h1, 4'h0, "t2_press_quiet");
    expect_at(c + 26, SEL_PR, 4'h1, 4'h1, "t2_press");
    expect_win(c + 27, c + 35, SEL_PR, 4'h1, 4'h0, "t2_single_press");
    for (int k = 0; k < 5; k++) begin
      btn[0] = 1'b1;
      step(2);
      btn[0] = 1'b0;
      step(2);
    end
    btn[0] = 1'b1;
    step(12);
    btn = 4'h0;
    step(10);

    // 3: toggle mode on channel 2 (fresh reset so tog and blink start at 0)
    rst = 1'b1;
    step(2);
    rst  = 1'b0;
    mode = 2'd1;
    btn  = 4'h4;
    cr = cyc;
    c  = cyc;
    expect_at(c + 6, SEL_PR, 4'hF, 4'h4, "t3_press1");
    expect_win(c + 1,  c + 7,  SEL_LED, 4'hF, 4'h0, "t3_led_before");
    expect_win(c + 8,  c + 27, SEL_LED, 4'hF, 4'h4, "t3_led_on");
    expect_win(c + 28, c + 39, SEL_LED, 4'hF, 4'h0, "t3_led_off");
    step(10);
    btn = 4'h0;
    step(10);
    btn = 4'h4;
    step(10);
    btn = 4'h0;
    step(10);

    // 4: blink mode on channel 1, then off, then back to toggle
    btn = 4'h2;
    c = cyc;
    expect_at(c + 8, SEL_LED, 4'hF, 4'h2, "t4_tog_set");
    step(10);
    btn = 4'h0;
    step(4);
    mode = 2'd2;
    cm = cyc;
    for (int k = 1; k <= 32; k++) begin
      e  = cm + k;
      ev = ((((e - 1 - cr) / BLK) % 2) == 1) ? 4'h2 : 4'h0;
      expect_at(e, SEL_LED, 4'hF, ev, "t4_blink");
    end
    step(32);
    mode = 2'd3;
    expect_at(cm + 33, SEL_LED, 4'hF, 4'h0, "t4_mode_off");
    expect_at(cm + 34, SEL_LED, 4'hF, 4'h0, "t4_mode_off_hold");
    step(2);
    mode = 2'd1;
    expect_at(cm + 35, SEL_LED, 4'hF, 4'h2, "t4_tog_kept");
    step(4);

    // 5: reset lands while channel 3 is mid-debounce
    btn = 4'h8;
    c = cyc;
    expect_win(c + 1, c + 4, SEL_PR, 4'hF, 4'h0, "t5_no_early_press");
    expect_win(c + 1, c + 4, SEL_DB, 4'h8, 4'h0, "t5_db_early");
    step(4);
    rst = 1'b1;
    expect_at(c + 5, SEL_DB,  4'hF, 4'h0, "t5_rst_db");
    expect_at(c + 5, SEL_PR,  4'hF, 4'h0, "t5_rst_press");
    expect_at(c + 5, SEL_LED, 4'hF, 4'h0, "t5_rst_led");
    step(1);
    rst = 1'b0;
    c = cyc;
    expect_win(c + 1, c + 5, SEL_DB, 4'h8, 4'h0, "t5_db_wait");
    expect_at(c + 6, SEL_DB, 4'h8, 4'h8, "t5_db_rise");
    expect_win(c + 1, c + 5, SEL_PR, 4'h8, 4'h0, "t5_press_quiet");
    expect_at(c + 6, SEL_PR, 4'h8, 4'h8, "t5_press");
    expect_at(c + 7, SEL_PR, 4'h8, 4'h0, "t5_press_end");
    step(10);
    btn = 4'h0;
    step(10);

    // 6: direct mode with channel 0 held, with or without dimming
    rst = 1'b1;
    step(2);
    rst  = 1'b0;
    mode = 2'd0;
    btn  = 4'h1;
    c = cyc;
    for (int k = 7; k <= 26; k++) begin
`ifdef BTN_LED_DIM_EN
      ev = ((k % 4) == 0) ? 4'h1 : 4'h0;
`else
      ev = 4'h1;
`endif
      expect_at(c + k, SEL_LED, 4'h1, ev, "t6_led_dim");
    end
    step(30);

    step(2);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
